// File: rtl/usr_shift_ctrl.sv
// Command sequencer for one universal shift register: load, shift N times, return the word.
// Optional rotate support is enabled by defining USR_SHIFT_CTRL_ROTATE_EN.
module usr_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_fill,
  input  logic             cmd_rotate,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_din,
  output logic             usr_s_left,
  output logic             usr_s_right,
  input  logic [WIDTH-1:0] usr_dout
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, amt_q;
  logic [WIDTH-1:0] data_q;
  logic             dir_q, fill_q, rot_q;
  logic             shift_in;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      amt_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (cmd_valid) begin
          data_q <= cmd_data;
          dir_q  <= cmd_dir;
          amt_q  <= cmd_amt;
          fill_q <= cmd_fill;
          rot_q  <= cmd_rotate;
        end
        LOAD:    cnt_q <= amt_q;
        SHIFT:   cnt_q <= cnt_q - AMT_W'(1);
        default: ;
      endcase
    end
  end

`ifdef USR_SHIFT_CTRL_ROTATE_EN
  // Rotating feeds the bit leaving the register back in at the opposite end.
  always_comb begin
    shift_in = fill_q;
    if (rot_q) shift_in = dir_q ? usr_dout[WIDTH-1] : usr_dout[0];
  end
`else
  logic unused_rotate;
  assign unused_rotate = rot_q;
  assign shift_in      = fill_q;
`endif

  // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    busy        = (state_q != IDLE);
    usr_select  = SEL_HOLD;
    usr_din     = '0;
    usr_s_left  = 1'b0;
    usr_s_right = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = LOAD;
      end
      LOAD: begin
        usr_select = SEL_LOAD;
        usr_din    = data_q;
        state_d    = (amt_q == '0) ? RESP : SHIFT;
      end
      SHIFT: begin
        usr_din = data_q;
        if (dir_q) begin
          usr_select = SEL_LEFT;
          usr_s_left = shift_in;
        end else begin
          usr_select  = SEL_RIGHT;
          usr_s_right = shift_in;
        end
        if (cnt_q == AMT_W'(1)) state_d = RESP;
      end
      RESP: begin
        usr_din   = data_q;
        rsp_valid = 1'b1;
        rsp_data  = usr_dout;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed bench for usr_shift_ctrl driving a behavioural 4-bit universal shift register.
// Rotate expectations follow USR_SHIFT_CTRL_ROTATE_EN when it is defined.
module tb_usr_shift_ctrl;
  localparam int WIDTH = 4;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir, cmd_fill, cmd_rotate;
  logic [AMT_W-1:0] cmd_amt;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic [1:0]       usr_select;
  logic [WIDTH-1:0] usr_din, usr_dout;
  logic             usr_s_left, usr_s_right;
  logic [WIDTH-1:0] usr_q = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  usr_shift_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_dir(cmd_dir), .cmd_amt(cmd_amt), .cmd_fill(cmd_fill), .cmd_rotate(cmd_rotate),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .usr_select(usr_select), .usr_din(usr_din),
    .usr_s_left(usr_s_left), .usr_s_right(usr_s_right), .usr_dout(usr_dout)
  );

  // Universal shift register: s_left enters at bit 0, s_right at bit WIDTH-1.
  always @(posedge clk) begin
    case (usr_select)
      2'b01:   usr_q <= {usr_s_right, usr_q[WIDTH-1:1]};
      2'b10:   usr_q <= {usr_q[WIDTH-2:0], usr_s_left};
      2'b11:   usr_q <= usr_din;
      default: usr_q <= usr_q;
    endcase
  end
  assign usr_dout = usr_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("tag=%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [WIDTH-1:0] d, input logic dir, input logic [AMT_W-1:0] amt,
                         input logic fill, input logic rot);
    cmd_data   = d;
    cmd_dir    = dir;
    cmd_amt    = amt;
    cmd_fill   = fill;
    cmd_rotate = rot;
  endtask

  // Issue one command from IDLE, wait the fixed amt+1 edges into RESP, check, then retire it.
  task automatic run_cmd(input string tag, input logic [WIDTH-1:0] d, input logic dir,
                         input logic [AMT_W-1:0] amt, input logic fill, input logic rot,
                         input logic [WIDTH-1:0] exp);
    set_cmd(d, dir, amt, fill, rot);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i <= int'(amt); i++) tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"},  32'(rsp_data),  32'(exp));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    set_cmd(4'b1111, 1'b0, 3'd2, 1'b1, 1'b0);

    // Reset held two edges with a command offered.
    tick(); tick();
    check("rst_select", 32'(usr_select), 32'd0);
    check("rst_ready",  32'(cmd_ready),  32'd1);
    check("rst_rvalid", 32'(rsp_valid),  32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_rdata",  32'(rsp_data),   32'd0);
    check("rst_din",    32'(usr_din),    32'd0);
    check("rst_serial", 32'({usr_s_left, usr_s_right}), 32'd0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Right shift by 1 with fill 1: 1010 -> 1101.
    set_cmd(4'b1010, 1'b0, 3'd1, 1'b1, 1'b0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("r_sel0",   32'(usr_select), 32'd3);
    check("r_din",    32'(usr_din),    32'hA);
    check("r_ready0", 32'(cmd_ready),  32'd0);
    check("r_busy0",  32'(busy),       32'd1);
    tick();
    check("r_sel1",    32'(usr_select),  32'd1);
    check("r_sright",  32'(usr_s_right), 32'd1);
    check("r_sleft",   32'(usr_s_left),  32'd0);
    check("r_rvalid1", 32'(rsp_valid),   32'd0);
    tick();
    check("r_sel2",   32'(usr_select), 32'd0);
    check("r_rvalid", 32'(rsp_valid),  32'd1);
    check("r_rdata",  32'(rsp_data),   32'hD);
    tick();
    check("r_rvalid_e3", 32'(rsp_valid), 32'd1);
    check("r_rdata_e3",  32'(rsp_data),  32'hD);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("r_done_ready",  32'(cmd_ready), 32'd1);
    check("r_done_rvalid", 32'(rsp_valid), 32'd0);

    // Left shift by 2 with fill 0: 1010 -> 1000.
    set_cmd(4'b1010, 1'b1, 3'd2, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("l_sel0", 32'(usr_select), 32'd3);
    tick();
    check("l_sel1",   32'(usr_select),  32'd2);
    check("l_sright", 32'(usr_s_right), 32'd0);
    tick();
    check("l_sel2",    32'(usr_select), 32'd2);
    check("l_rvalid2", 32'(rsp_valid),  32'd0);
    tick();
    check("l_sel3",   32'(usr_select), 32'd0);
    check("l_rvalid", 32'(rsp_valid),  32'd1);
    check("l_rdata",  32'(rsp_data),   32'h8);
    tick();
    check("l_rdata_e4", 32'(rsp_data), 32'h8);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Zero amount under backpressure, with a second command waiting.
    set_cmd(4'b0110, 1'b0, 3'd0, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    tick();
    set_cmd(4'b1111, 1'b1, 3'd0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_rvalid", 32'(rsp_valid),  32'd1);
      check("bp_rdata",  32'(rsp_data),   32'h6);
      check("bp_ready",  32'(cmd_ready),  32'd0);
      check("bp_sel",    32'(usr_select), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_ready", 32'(cmd_ready), 32'd1);
    check("bp_idle_busy",  32'(busy),      32'd0);
    check("bp_rvalid_low", 32'(rsp_valid), 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("bp2_sel",  32'(usr_select), 32'd3);
    check("bp2_din",  32'(usr_din),    32'hF);
    tick();
    check("bp2_rdata", 32'(rsp_data), 32'hF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Rotate requests; without the feature the fill bit (0) is used.
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    run_cmd("rot_left",  4'b1001, 1'b1, 3'd1, 1'b0, 1'b1, 4'b0011);
    run_cmd("rot_right", 4'b1001, 1'b0, 3'd3, 1'b0, 1'b1, 4'b0011);
`else
    run_cmd("rot_left",  4'b1001, 1'b1, 3'd1, 1'b0, 1'b1, 4'b0010);
    run_cmd("rot_right", 4'b1001, 1'b0, 3'd3, 1'b0, 1'b1, 4'b0001);
`endif

    // Amounts beyond WIDTH fill entirely.
    run_cmd("max_right", 4'b0000, 1'b0, 3'd7, 1'b1, 1'b0, 4'b1111);
    run_cmd("big_left",  4'b1011, 1'b1, 3'd5, 1'b0, 1'b0, 4'b0000);
    run_cmd("fill_left", 4'b0001, 1'b1, 3'd3, 1'b1, 1'b0, 4'b1111);

    // Reset sampled at the third shift edge of a 5-shift command.
    set_cmd(4'b1111, 1'b0, 3'd5, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    check("mr_sel_pre", 32'(usr_select), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_sel",   32'(usr_select), 32'd0);
    check("mr_busy",  32'(busy),       32'd0);
    check("mr_ready", 32'(cmd_ready),  32'd1);
    check("mr_din",   32'(usr_din),    32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mr_no_rsp", 32'(rsp_valid), 32'd0);
    end

    run_cmd("after_rst", 4'b1010, 1'b0, 3'd1, 1'b1, 1'b0, 4'b1101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
